conjunto_reg_param: RTL and testbench
=====================================

# conjunto_reg_param

Parametrised successor to the 32x32 register file, for the rv32i datapath. It provides one synchronous write port and two registered read ports with per-port read enables. Width and depth are configurable, and register 0 can be hardwired to zero. After reset, a sequential clear sweep zeroes every register, so the storage can map onto inferred RAM, and a `listo` flag marks when the block is usable. An optional write-to-read bypass is selected at compile time.

## Interface
- `ANCHO_DATOS`, default 32: data width in bits.
- `ANCHO_DIR`, default 5: address width; depth `NUM_REG = 2**ANCHO_DIR`.
- `REG0_CERO`, default 1: 1 makes register 0 read as zero and discards writes to it; 0 makes it an ordinary register.
- `clk`  in  1  single clock; everything is updated on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `hab_w`  in  1  write enable.
- `addr_w`  in  ANCHO_DIR  write address.
- `data_w`  in  ANCHO_DATOS  write data.
- `hab_r1`  in  1  read enable, port 1.
- `addr_r1`  in  ANCHO_DIR  read address, port 1.
- `data_r1`  out  ANCHO_DATOS  registered read data, port 1.
- `hab_r2`  in  1  read enable, port 2.
- `addr_r2`  in  ANCHO_DIR  read address, port 2.
- `data_r2`  out  ANCHO_DATOS  registered read data, port 2.
- `listo`  out  1  high once the clear sweep has finished and the block accepts reads and writes.

## Operation
- The block has two states, LIMPIANDO and OPERATIVO, and a sweep counter `cnt` of ANCHO_DIR+1 bits.
- Edge with `rst`=1:
  - state goes to LIMPIANDO, `cnt`=0, `listo`=0, `data_r1`=`data_r2`=0.
  - This is the reset value of every output.
  - It applies from any state, including mid-sweep; the sweep restarts.
- LIMPIANDO, edge with `rst`=0:
  - register[`cnt`] is written with 0 and `cnt` increments.
  - When `cnt` reaches NUM_REG-1 on that edge, the state goes to OPERATIVO and `listo` goes to 1.
  - `hab_w`, `hab_r1` and `hab_r2` are ignored; `data_r*` hold 0.
- OPERATIVO, write: `hab_w`=1 stores `data_w` into register[`addr_w`] at the edge. With REG0_CERO=1 and `addr_w`=0 the write is discarded.
- OPERATIVO, read port n:
  - `hab_rn`=1: `data_rn` is loaded at the edge with register[`addr_rn`] (0 when REG0_CERO=1 and the address is 0).
  - `hab_rn`=0: `data_rn` holds its previous value regardless of address changes.
- Both ports may read the same address in the same cycle and get identical data.
- Write/read collision without bypass (read-first): the read returns the pre-write value; the new value is visible on the next read.
- The state stays OPERATIVO until the next `rst`.

## Timing
- Read latency: 1 cycle. Address and enable are sampled at edge k; data is valid after edge k and stable until the next enabled edge.
- Write latency: the value is stored at edge k and readable by a read sampled at edge k+1, or at edge k with bypass.
- Clear sweep: with `rst` sampled high at edge k and low from edge k+1 on, registers 0 through NUM_REG-1 are cleared at edges k+1 through k+NUM_REG.
  - `listo`=1 after edge k+NUM_REG; 32 cycles at default parameters.
  - Holding `rst` high keeps `cnt`=0 and `listo`=0.
- There is no combinational path from inputs to outputs. All outputs are flops.

## Configuration
- Macro: `CONJUNTO_REG_BYPASS_EN`.
- Defined: in OPERATIVO, a read with `hab_rn`=1 and `addr_rn`==`addr_w` while `hab_w`=1 loads `data_w` into `data_rn` at the same edge (write-first).
  - Not applied when REG0_CERO=1 and the address is 0; that read still returns 0.
  - Applies to both ports independently.
- Undefined: read-first behaviour as described under Operation. No comparator logic is generated.

## Test plan
- Reset sweep: `rst`=1 for 1 edge, then 0 → `listo`=0 for 32 edges, 1 after the 32nd; `data_r1`=`data_r2`=0 throughout. Write attempts to reg 5 during the sweep (`data_w`=0xFFFF_FFFF) are absent when reg 5 is read afterwards (reads 0).
- Register 0: write 0x1111_1111 to addr 0, then read addr 0 on both ports → 0x0000_0000. With REG0_CERO=0 → 0x1111_1111.
- Write and dual read:
  - Write reg1=0x5041_544F and reg2=0xDEAD_BEEF, then `addr_r1`=1, `addr_r2`=2 → port 1 reads 0x5041_544F and port 2 reads 0xDEAD_BEEF after one edge.
  - Then `addr_r1`=`addr_r2`=1 → both read 0x5041_544F.
- Hold on disable: with `hab_r1`=`hab_r2`=0, change the addresses to 2 and 0 → outputs keep 0x5041_544F for 3 edges.
- Collision: reg3=0xAAAA_AAAA, then write 0x5555_5555 to reg3 while reading reg3 on port 1 at the same edge.
  - With `CONJUNTO_REG_BYPASS_EN` → 0x5555_5555.
  - Without it → 0xAAAA_AAAA, then 0x5555_5555 on the next read.
- Reset mid-operation:
  - Fill reg7=0x1234_5678, then assert `rst` for 1 edge during OPERATIVO → `data_r*`=0 and `listo`=0.
  - Reassert `rst` at sweep cycle 10 → the sweep restarts and `listo` rises 32 edges after the last reset edge.
  - Reg7 reads 0 afterwards.
- Parametrisation: ANCHO_DATOS=16, ANCHO_DIR=3 → sweep lasts 8 cycles; writing 0xBEEF to reg7 reads back 0xBEEF.

Source files
------------

// File: rtl/conjunto_reg_param.sv
// Parametrised register file: one write port, two registered read ports.
// Optional write-to-read bypass with macro CONJUNTO_REG_BYPASS_EN.
module conjunto_reg_param #(
  parameter int ANCHO_DATOS = 32,
  parameter int ANCHO_DIR   = 5,
  parameter bit REG0_CERO   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hab_w,
  input  logic [ANCHO_DIR-1:0]   addr_w,
  input  logic [ANCHO_DATOS-1:0] data_w,
  input  logic                   hab_r1,
  input  logic [ANCHO_DIR-1:0]   addr_r1,
  output logic [ANCHO_DATOS-1:0] data_r1,
  input  logic                   hab_r2,
  input  logic [ANCHO_DIR-1:0]   addr_r2,
  output logic [ANCHO_DATOS-1:0] data_r2,
  output logic                   listo
);

  localparam int NUM_REG = 2 ** ANCHO_DIR;
  localparam int CNT_W   = ANCHO_DIR + 1;
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(NUM_REG - 1);

  typedef enum logic {
    LIMPIANDO,
    OPERATIVO
  } estado_t;

  estado_t estado;
  estado_t estado_sig;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_sig;

  logic [ANCHO_DATOS-1:0] mem [NUM_REG];

  logic                   we;
  logic [ANCHO_DIR-1:0]   wa;
  logic [ANCHO_DATOS-1:0] wd;
  logic                   w_cero;

  logic [ANCHO_DATOS-1:0] rd1;
  logic [ANCHO_DATOS-1:0] rd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= LIMPIANDO;
      cnt    <= '0;
      listo  <= 1'b0;
    end else begin
      estado <= estado_sig;
      cnt    <= cnt_sig;
      listo  <= (estado_sig == OPERATIVO);
    end
  end

  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    unique case (estado)
      LIMPIANDO: begin
        cnt_sig = cnt + CNT_W'(1);
        if (cnt == CNT_FIN)
          estado_sig = OPERATIVO;
      end
      OPERATIVO: estado_sig = OPERATIVO;
    endcase
  end

  // The sweep borrows the single write port, keeping mem RAM-shaped.
  assign w_cero = REG0_CERO && (addr_w == '0);

  always_comb begin
    we = 1'b0;
    wa = addr_w;
    wd = data_w;
    if (!rst) begin
      unique case (estado)
        LIMPIANDO: begin
          we = 1'b1;
          wa = cnt[ANCHO_DIR-1:0];
          wd = '0;
        end
        OPERATIVO: we = hab_w && !w_cero;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= wd;
  end

  always_comb begin
    rd1 = mem[addr_r1];
`ifdef CONJUNTO_REG_BYPASS_EN
    if (hab_w && addr_r1 == addr_w)
      rd1 = data_w;
`endif
    if (REG0_CERO && addr_r1 == '0)
      rd1 = '0;
  end

  always_comb begin
    rd2 = mem[addr_r2];
`ifdef CONJUNTO_REG_BYPASS_EN
    if (hab_w && addr_r2 == addr_w)
      rd2 = data_w;
`endif
    if (REG0_CERO && addr_r2 == '0)
      rd2 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst || estado == LIMPIANDO) begin
      data_r1 <= '0;
      data_r2 <= '0;
    end else begin
      if (hab_r1)
        data_r1 <= rd1;
      if (hab_r2)
        data_r2 <= rd2;
    end
  end

endmodule

// File: tb/tb_conjunto_reg_param.sv
// Bench for conjunto_reg_param: default instance plus a 16x8, REG0_CERO=0 one.
// Behavioural model in plain arrays, compared every negedge after reset.
module tb_conjunto_reg_param;

  logic clk;

  logic        a_rst, a_hw, a_h1, a_h2, a_listo;
  logic [4:0]  a_aw, a_a1, a_a2;
  logic [31:0] a_dw, a_r1, a_r2;

  logic        b_rst, b_hw, b_h1, b_h2, b_listo;
  logic [2:0]  b_aw, b_a1, b_a2;
  logic [15:0] b_dw, b_r1, b_r2;

  int errors = 0;
  int checks = 0;

  conjunto_reg_param dut_a (
    .clk(clk), .rst(a_rst),
    .hab_w(a_hw), .addr_w(a_aw), .data_w(a_dw),
    .hab_r1(a_h1), .addr_r1(a_a1), .data_r1(a_r1),
    .hab_r2(a_h2), .addr_r2(a_a2), .data_r2(a_r2),
    .listo(a_listo)
  );

  conjunto_reg_param #(
    .ANCHO_DATOS(16), .ANCHO_DIR(3), .REG0_CERO(1'b0)
  ) dut_b (
    .clk(clk), .rst(b_rst),
    .hab_w(b_hw), .addr_w(b_aw), .data_w(b_dw),
    .hab_r1(b_h1), .addr_r1(b_a1), .data_r1(b_r1),
    .hab_r2(b_h2), .addr_r2(b_a2), .data_r2(b_r2),
    .listo(b_listo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference model ----
  logic        in_rst [2];
  logic        in_hw  [2];
  logic        in_h1  [2];
  logic        in_h2  [2];
  logic [4:0]  in_aw  [2];
  logic [4:0]  in_a1  [2];
  logic [4:0]  in_a2  [2];
  logic [31:0] in_dw  [2];

  always_comb begin
    in_rst[0] = a_rst; in_rst[1] = b_rst;
    in_hw[0]  = a_hw;  in_hw[1]  = b_hw;
    in_h1[0]  = a_h1;  in_h1[1]  = b_h1;
    in_h2[0]  = a_h2;  in_h2[1]  = b_h2;
    in_aw[0]  = a_aw;  in_aw[1]  = {2'b0, b_aw};
    in_a1[0]  = a_a1;  in_a1[1]  = {2'b0, b_a1};
    in_a2[0]  = a_a2;  in_a2[1]  = {2'b0, b_a2};
    in_dw[0]  = a_dw;  in_dw[1]  = {16'h0, b_dw};
  end

  logic [31:0] mm [2][32];
  logic [31:0] er1 [2];
  logic [31:0] er2 [2];
  int          since [2];
  logic        known [2] = '{1'b0, 1'b0};

  function automatic int dep(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic logic z0(input int i);
    return (i == 0);
  endfunction

  function automatic logic [31:0] rdv(input int i, input logic [4:0] a);
    if (z0(i) && a == 5'd0)
      return 32'h0;
`ifdef CONJUNTO_REG_BYPASS_EN
    if (in_hw[i] && a == in_aw[i])
      return in_dw[i];
`endif
    return mm[i][a];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (in_rst[i]) begin
        known[i] <= 1'b1;
        since[i] <= 0;
        er1[i]   <= '0;
        er2[i]   <= '0;
        for (int j = 0; j < 32; j++)
          mm[i][j] <= '0;
      end else if (since[i] < dep(i)) begin
        since[i] <= since[i] + 1;
        er1[i]   <= '0;
        er2[i]   <= '0;
      end else begin
        if (in_hw[i] && !(z0(i) && in_aw[i] == 5'd0))
          mm[i][in_aw[i]] <= in_dw[i];
        if (in_h1[i])
          er1[i] <= rdv(i, in_a1[i]);
        if (in_h2[i])
          er2[i] <= rdv(i, in_a2[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (known[0]) begin
      chk("a_listo", {31'h0, a_listo}, {31'h0, since[0] >= 32});
      chk("a_r1", a_r1, er1[0]);
      chk("a_r2", a_r2, er2[0]);
    end
    if (known[1]) begin
      chk("b_listo", {31'h0, b_listo}, {31'h0, since[1] >= 8});
      chk("b_r1", {16'h0, b_r1}, er1[1]);
      chk("b_r2", {16'h0, b_r2}, er2[1]);
    end
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    a_hw = 0; a_h1 = 0; a_h2 = 0;
    b_hw = 0; b_h1 = 0; b_h2 = 0;
  endtask

  task automatic sweep_wait(input string nm);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk({nm, "_a"}, {31'h0, a_listo}, {31'h0, i == 32});
      chk({nm, "_b"}, {31'h0, b_listo}, {31'h0, i >= 8});
    end
  endtask

  logic [31:0] col_exp;

  initial begin
    a_rst = 1; b_rst = 1;
    a_aw = 0; a_a1 = 0; a_a2 = 0; a_dw = 0;
    b_aw = 0; b_a1 = 0; b_a2 = 0; b_dw = 0;
    idle();
    tick();
    chk("rst_listo", {31'h0, a_listo}, 32'h0);
    chk("rst_r1", a_r1, 32'h0);
    a_rst = 0; b_rst = 0;
    // writes and reads during the sweep must be ignored
    a_hw = 1; a_aw = 5; a_dw = 32'hFFFF_FFFF;
    a_h1 = 1; a_a1 = 5;
    sweep_wait("sweep");
    idle();
    a_h1 = 1; a_a1 = 5;
    tick();
    chk("reg5_clear", a_r1, 32'h0);

    idle();
    a_hw = 1; a_aw = 0; a_dw = 32'h1111_1111;
    b_hw = 1; b_aw = 0; b_dw = 16'h1111;
    tick();
    idle();
    a_h1 = 1; a_a1 = 0; a_h2 = 1; a_a2 = 0;
    b_hw = 1; b_aw = 7; b_dw = 16'hBEEF;
    b_h1 = 1; b_a1 = 0;
    tick();
    chk("reg0_r1", a_r1, 32'h0);
    chk("reg0_r2", a_r2, 32'h0);
    chk("b_reg0", {16'h0, b_r1}, 32'h1111);
    idle();
    b_h1 = 1; b_a1 = 7;
    a_hw = 1; a_aw = 1; a_dw = 32'h5041_544F;
    tick();
    chk("b_reg7", {16'h0, b_r1}, 32'hBEEF);
    idle();
    a_hw = 1; a_aw = 2; a_dw = 32'hDEAD_BEEF;
    tick();
    idle();
    a_h1 = 1; a_a1 = 1; a_h2 = 1; a_a2 = 2;
    tick();
    chk("dual_r1", a_r1, 32'h5041_544F);
    chk("dual_r2", a_r2, 32'hDEAD_BEEF);
    a_a2 = 1;
    tick();
    chk("same_r1", a_r1, 32'h5041_544F);
    chk("same_r2", a_r2, 32'h5041_544F);
    idle();
    a_a1 = 2; a_a2 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_r1", a_r1, 32'h5041_544F);
      chk("hold_r2", a_r2, 32'h5041_544F);
    end

    a_hw = 1; a_aw = 3; a_dw = 32'hAAAA_AAAA;
    tick();
    a_dw = 32'h5555_5555;
    a_h1 = 1; a_a1 = 3;
    tick();
`ifdef CONJUNTO_REG_BYPASS_EN
    col_exp = 32'h5555_5555;
`else
    col_exp = 32'hAAAA_AAAA;
`endif
    chk("collide", a_r1, col_exp);
    a_hw = 0;
    tick();
    chk("after_col", a_r1, 32'h5555_5555);

    idle();
    a_hw = 1; a_aw = 7; a_dw = 32'h1234_5678;
    tick();
    idle();
    a_rst = 1; b_rst = 1;
    tick();
    chk("mid_r1", a_r1, 32'h0);
    chk("mid_r2", a_r2, 32'h0);
    chk("mid_listo", {31'h0, a_listo}, 32'h0);
    a_rst = 0; b_rst = 0;
    for (int i = 0; i < 10; i++) tick();
    a_rst = 1; b_rst = 1;
    tick();
    a_rst = 0; b_rst = 0;
    sweep_wait("resweep");
    a_h1 = 1; a_a1 = 7;
    tick();
    chk("reg7_clear", a_r1, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      a_rst = ($urandom_range(0, 299) == 0);
      a_hw = $urandom_range(0, 1) == 1;
      a_h1 = $urandom_range(0, 1) == 1;
      a_h2 = $urandom_range(0, 1) == 1;
      a_aw = 5'($urandom_range(0, 7));
      a_a1 = 5'($urandom_range(0, 7));
      a_a2 = 5'($urandom_range(0, 7));
      a_dw = $urandom;
      b_rst = ($urandom_range(0, 299) == 0);
      b_hw = $urandom_range(0, 1) == 1;
      b_h1 = $urandom_range(0, 1) == 1;
      b_h2 = $urandom_range(0, 1) == 1;
      b_aw = 3'($urandom_range(0, 7));
      b_a1 = 3'($urandom_range(0, 7));
      b_a2 = 3'($urandom_range(0, 7));
      b_dw = 16'($urandom);
      tick();
    end
    a_rst = 0; b_rst = 0;
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
